pcie_egress_drain: RTL

//  Consumer end of the 4-port PCIE switch egress. Pops the four output FIFOs (fifo4..fifo7) round-robin.

---
 rtl/pcie_egress_drain_pkg.sv | 45 ++++
 rtl/pcie_egress_drain_if.sv | 13 +
 rtl/pcie_egress_drain_skid_buf.sv | 77 +++++++
 rtl/pcie_egress_drain.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pcie_egress_drain_pkg.sv
// Shared types and constants for the PCIE egress drain: word layout,
// counter width, FSM encoding, skid entry format and the round-robin helper.
package pcie_egress_drain_pkg;

  localparam int TAMANO_DATOS = 12;
  localparam int CNT_W        = 5;
  localparam int N_PORTS      = 4;
  localparam int PORT_W       = 2;

  // Field positions inside a switch word
  localparam int DEST_LSB  = 8;
  localparam int DEST_MSB  = 9;
  localparam int CLASS_LSB = 10;
  localparam int CLASS_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STALL = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [PORT_W-1:0]       port;
    logic [TAMANO_DATOS-1:0] data;
  } skid_entry_t;

  // First candidate scanning upward from rr (mod N_PORTS).
  // Returns {found, index}; lower scan distance overrides higher.
  function automatic logic [PORT_W:0] rr_pick(input logic [N_PORTS-1:0] cand,
                                              input logic [PORT_W-1:0]  rr);
    logic [PORT_W:0]   res;
    logic [PORT_W-1:0] p;
    res = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      p = rr + PORT_W'(k);
      if (cand[p]) begin
        res = {1'b1, p};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pcie_egress_drain_if.sv
// Merged egress stream: one word plus its source port, valid/ready handshake.
interface pcie_egress_drain_if;
  import pcie_egress_drain_pkg::*;

  logic [TAMANO_DATOS-1:0] out_data;
  logic [PORT_W-1:0]       out_port;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output out_data, output out_port, output out_valid, input out_ready);
  modport slave  (input out_data, input out_port, input out_valid, output out_ready);

endinterface

// File: rtl/pcie_egress_drain_skid_buf.sv
// Two-entry {port,data} FIFO between the FIFO read path and the merged
// output stream. Head stays put until it is accepted downstream.
module egress_skid_buf
  import pcie_egress_drain_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  skid_entry_t push_entry,
  input  logic        ready,
  output logic        valid,
  output skid_entry_t head,
  output logic [1:0]  occ
);

  skid_entry_t mem_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  occ_r;
  logic [1:0]  occ_nxt_s;
  logic        deq_s;

  assign valid = (occ_r != 2'd0);
  assign head  = mem_r[rd_ptr_r];
  assign occ   = occ_r;
  assign deq_s = valid && ready;

  // Occupancy update; simultaneous push and dequeue leave it unchanged
  always_comb begin
    occ_nxt_s = occ_r;
    case ({push, deq_s})
      2'b10:   occ_nxt_s = occ_r + 2'd1;
      2'b01:   occ_nxt_s = occ_r - 2'd1;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Storage and pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_nxt_s;
    end
  end

  egress_skid_buf_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .occ   (occ_r)
  );

endmodule

// Overflow guard: the credit rule upstream must keep a capture away from a full buffer.
module egress_skid_buf_chk (
  input logic       clk,
  input logic       reset,
  input logic       push,
  input logic [1:0] occ
);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && (occ == 2'd2)));

endmodule

// File: rtl/pcie_egress_drain.sv
// Consumer end of the 4-port switch egress: round-robin pops of fifo4..fifo7,
// merge through a 2-entry skid buffer, per-port pop counters readable in idle.
module pcie_egress_drain
  import pcie_egress_drain_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_PORTS-1:0]      empty,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  output logic [N_PORTS-1:0]      pop,
  pcie_egress_drain_if.master     out_if,
  input  logic                    req,
  input  logic [PORT_W-1:0]       idx,
  output logic [CNT_W-1:0]        cnt_data,
  output logic                    cnt_valid,
  output logic                    idle
);

  drain_state_e            state_r, state_nxt_s;
  logic [PORT_W-1:0]       rr_r;
  logic                    inflight_vld_r;
  logic [PORT_W-1:0]       inflight_port_r;
  logic [CNT_W-1:0]        cnt_r [N_PORTS];
  logic [CNT_W-1:0]        cnt_data_r;
  logic                    cnt_valid_r;
  logic [PORT_W:0]         pick_s;
  logic                    credit_s;
  logic                    idle_cond_s;
  logic [N_PORTS-1:0]      pop_s;
  logic                    idle_s;
  logic                    pop_fire_s;
  logic [PORT_W-1:0]       grant_s;
  logic [TAMANO_DATOS-1:0] cap_data_s;
  logic [1:0]              occ_s;
  skid_entry_t             cap_entry_s;
  skid_entry_t             head_s;
  logic                    head_vld_s;

  assign pop        = pop_s;
  assign idle       = idle_s;
  assign cnt_data   = cnt_data_r;
  assign cnt_valid  = cnt_valid_r;
  assign pop_fire_s = |pop_s;
  assign grant_s    = pick_s[PORT_W-1:0];

  // Arbitration candidate and credit: never more than two words owed to the buffer
  always_comb begin
    pick_s      = rr_pick(~empty, rr_r);
    credit_s    = (({1'b0, occ_s} + {2'b00, inflight_vld_r}) < 3'd2);
    idle_cond_s = (&empty) && (occ_s == 2'd0) && !inflight_vld_r;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!(&empty)) state_nxt_s = ST_DRAIN;
        else           state_nxt_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if ((occ_s == 2'd2) && !out_if.out_ready) state_nxt_s = ST_STALL;
        else if (idle_cond_s)                     state_nxt_s = ST_IDLE;
        else                                      state_nxt_s = ST_DRAIN;
      end
      ST_STALL: begin
        if (out_if.out_ready) state_nxt_s = ST_DRAIN;
        else                  state_nxt_s = ST_STALL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: one-hot pop only while draining with credit and a candidate
  always_comb begin
    pop_s  = '0;
    idle_s = 1'b0;
    case (state_r)
      ST_IDLE: idle_s = 1'b1;
      ST_DRAIN: begin
        if (credit_s && pick_s[PORT_W]) pop_s = {{(N_PORTS-1){1'b0}}, 1'b1} << grant_s;
        else                            pop_s = '0;
      end
      ST_STALL: pop_s = '0;
      default:  idle_s = 1'b0;
    endcase
  end

  // Round-robin pointer and the one-cycle FIFO read latency tracker
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_r            <= '0;
      inflight_vld_r  <= 1'b0;
      inflight_port_r <= '0;
    end else begin
      inflight_vld_r  <= pop_fire_s;
      inflight_port_r <= grant_s;
      if (pop_fire_s) begin
        rr_r <= grant_s + 2'd1;
      end
    end
  end

  // Select the word returned by the port popped last cycle
  always_comb begin
    case (inflight_port_r)
      2'd0:    cap_data_s = data_in0;
      2'd1:    cap_data_s = data_in1;
      2'd2:    cap_data_s = data_in2;
      default: cap_data_s = data_in3;
    endcase
    cap_entry_s = '{port: inflight_port_r, data: cap_data_s};
  end

  egress_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_vld_r),
    .push_entry (cap_entry_s),
    .ready      (out_if.out_ready),
    .valid      (head_vld_s),
    .head       (head_s),
    .occ        (occ_s)
  );

  assign out_if.out_valid = head_vld_s;
  assign out_if.out_data  = head_s.data;
  assign out_if.out_port  = head_s.port;

  // Per-port pop counters, counted at issue and wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) cnt_r[i] <= '0;
    end else if (pop_fire_s) begin
      cnt_r[grant_s] <= cnt_r[grant_s] + CNT_W'(1);
    end
  end

  // Counter read port: only honoured while idle, strobe lasts one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_valid_r <= 1'b0;
      cnt_data_r  <= '0;
    end else begin
      cnt_valid_r <= req && idle_s;
      if (req && idle_s) begin
        cnt_data_r <= cnt_r[idx];
      end
    end
  end

endmodule
